// File: rtl/i2c_cond_pkg.sv
// Shared types and default constants for the I2C pin-side bus conditioner.
package i2c_cond_pkg;

  localparam int unsigned FILTER_LEN_DEF    = 4;
  localparam int unsigned RECOVER_HALF_DEF  = 250;
  localparam int unsigned STUCK_TIMEOUT_DEF = 50000;
  localparam int unsigned RECOVER_PULSES    = 9;

  typedef enum logic [2:0] {
    ST_PASS,
    ST_REC_LOW,
    ST_REC_HIGH,
    ST_STOP_A,
    ST_STOP_B,
    ST_STOP_C
  } rec_state_e;

  // Bits needed to hold the values 0 .. n-1 (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/i2c_glitch_filter.sv
// Two-flop synchroniser followed by a run-length glitch filter; the output
// only follows the input after FILTER_LEN consecutive differing samples.
module i2c_glitch_filter
  import i2c_cond_pkg::*;
#(
  parameter int unsigned FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic filt_out
);

  localparam int unsigned CW = cnt_width(FILTER_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    cnt_d   = '0;
    // cnt_q counts how many differing samples were already seen in a row
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_out = filt_q;

endmodule

// File: rtl/i2c_bus_conditioner.sv
// Open-drain pin front-end for the fabric I2C master: filtering, START/STOP and
// stuck-bus detection, plus a 9-clock bus recovery built when I2C_COND_RECOVERY_EN is defined.
module i2c_bus_conditioner
  import i2c_cond_pkg::*;
#(
  parameter int unsigned FILTER_LEN    = FILTER_LEN_DEF,
  parameter int unsigned RECOVER_HALF  = RECOVER_HALF_DEF,
  parameter int unsigned STUCK_TIMEOUT = STUCK_TIMEOUT_DEF
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic i2c_scl_pad_o,
  input  logic i2c_sda_pad_o,
  input  logic i2c_scl_padoen_o,
  input  logic i2c_sda_padoen_o,
  output logic i2c_scl_pad_i,
  output logic i2c_sda_pad_i,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_oe,
  output logic sda_oe,
  input  logic recover_req,
  output logic recover_busy,
  output logic bus_busy,
  output logic start_det,
  output logic stop_det,
  output logic stuck_err,
  input  logic err_clr
);

  localparam int unsigned SCW = cnt_width(STUCK_TIMEOUT + 1);
  localparam logic [SCW-1:0] STUCK_MAX = SCW'(STUCK_TIMEOUT);

  logic scl_f, sda_f;
  logic rec_busy, rec_exit;
  logic scl_oe_q, scl_oe_d;
  logic sda_oe_q, sda_oe_d;

  // Open-drain pins only ever drive 0, so the core's output values carry no information.
  logic unused_pad_o;
  assign unused_pad_o = i2c_scl_pad_o ^ i2c_sda_pad_o;

  i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .raw_in   (scl_in),
    .filt_out (scl_f)
  );

  i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .raw_in   (sda_in),
    .filt_out (sda_f)
  );

`ifdef I2C_COND_RECOVERY_EN
  localparam int unsigned HCW = cnt_width(RECOVER_HALF);
  localparam logic [HCW-1:0] HALF_LAST = HCW'(RECOVER_HALF - 1);

  rec_state_e     state_q, state_d;
  logic [HCW-1:0] half_q, half_d;
  logic [3:0]     pulse_q, pulse_d;
  logic           half_done;

  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    pulse_d   = pulse_q;
    rec_exit  = 1'b0;
    half_done = (half_q == HALF_LAST);
    case (state_q)
      ST_PASS: begin
        if (recover_req) begin
          state_d = ST_REC_LOW;
          half_d  = '0;
          pulse_d = '0;
        end
      end
      ST_REC_LOW: begin
        if (half_done) begin
          state_d = ST_REC_HIGH;
          half_d  = '0;
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      ST_REC_HIGH: begin
        // A slave stretching SCL freezes the high half-period.
        if (scl_f) begin
          if (half_done) begin
            half_d  = '0;
            pulse_d = pulse_q + 4'd1;
            if (sda_f || (pulse_q == 4'(RECOVER_PULSES - 1))) begin
              state_d = ST_STOP_A;
            end else begin
              state_d = ST_REC_LOW;
            end
          end else begin
            half_d = half_q + 1'b1;
          end
        end
      end
      ST_STOP_A: begin
        if (half_done) begin
          state_d = ST_STOP_B;
          half_d  = '0;
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      ST_STOP_B: begin
        if (half_done) begin
          state_d = ST_STOP_C;
          half_d  = '0;
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      ST_STOP_C: begin
        if (half_done) begin
          state_d  = ST_PASS;
          half_d   = '0;
          rec_exit = 1'b1;
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_PASS;
        half_d  = '0;
      end
    endcase

    // Pin enables are decoded from the next state so they switch with it.
    case (state_d)
      ST_PASS: begin
        scl_oe_d = ~i2c_scl_padoen_o;
        sda_oe_d = ~i2c_sda_padoen_o;
      end
      ST_REC_LOW: begin
        scl_oe_d = 1'b1;
        sda_oe_d = 1'b0;
      end
      ST_STOP_A: begin
        scl_oe_d = 1'b1;
        sda_oe_d = 1'b1;
      end
      ST_STOP_B: begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b1;
      end
      default: begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q  <= ST_PASS;
      half_q   <= '0;
      pulse_q  <= '0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      half_q   <= half_d;
      pulse_q  <= pulse_d;
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
    end
  end

  assign rec_busy = (state_q != ST_PASS);
`else
  logic unused_rec;
  assign unused_rec = recover_req ^ (RECOVER_HALF == 0);

  always_comb begin
    scl_oe_d = ~i2c_scl_padoen_o;
    sda_oe_d = ~i2c_sda_padoen_o;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
    end else begin
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
    end
  end

  assign rec_busy = 1'b0;
  assign rec_exit = 1'b0;
`endif

  logic           sda_prev_q, sda_prev_d;
  logic           start_det_q, start_det_d;
  logic           stop_det_q, stop_det_d;
  logic           bus_busy_q, bus_busy_d;
  logic           stuck_err_q, stuck_err_d;
  logic [SCW-1:0] stuck_cnt_q, stuck_cnt_d;
  logic           start_now, stop_now;

  always_comb begin
    sda_prev_d  = sda_f;
    start_now   = sda_prev_q & ~sda_f & scl_f;
    stop_now    = ~sda_prev_q & sda_f & scl_f;
    start_det_d = start_now;
    stop_det_d  = stop_now;

    bus_busy_d = bus_busy_q;
    if (start_now) begin
      bus_busy_d = 1'b1;
    end else if (stop_now) begin
      bus_busy_d = 1'b0;
    end
    if (rec_exit) begin
      bus_busy_d = 1'b0;
    end

    stuck_cnt_d = stuck_cnt_q;
    if (rec_busy || (scl_f && sda_f)) begin
      stuck_cnt_d = '0;
    end else if (stuck_cnt_q != STUCK_MAX) begin
      stuck_cnt_d = stuck_cnt_q + 1'b1;
    end

    // Saturated counter re-asserts the flag, so a coincident clear loses.
    stuck_err_d = stuck_err_q & ~err_clr;
    if (stuck_cnt_q == STUCK_MAX) begin
      stuck_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sda_prev_q  <= 1'b1;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      bus_busy_q  <= 1'b0;
      stuck_err_q <= 1'b0;
      stuck_cnt_q <= '0;
    end else begin
      sda_prev_q  <= sda_prev_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
      bus_busy_q  <= bus_busy_d;
      stuck_err_q <= stuck_err_d;
      stuck_cnt_q <= stuck_cnt_d;
    end
  end

  assign scl_oe        = scl_oe_q;
  assign sda_oe        = sda_oe_q;
  assign i2c_scl_pad_i = rec_busy ? 1'b1 : scl_f;
  assign i2c_sda_pad_i = rec_busy ? 1'b1 : sda_f;
  assign recover_busy  = rec_busy;
  assign bus_busy      = bus_busy_q;
  assign start_det     = start_det_q;
  assign stop_det      = stop_det_q;
  assign stuck_err     = stuck_err_q;

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// Self-checking bench for i2c_bus_conditioner with a wired-AND bus model;
// recovery scenarios are exercised when I2C_COND_RECOVERY_EN is defined.
module tb_i2c_bus_conditioner;

  localparam logic [1:0] EV_START = 2'd1;
  localparam logic [1:0] EV_STOP  = 2'd2;

  logic clk = 1'b0;
  logic rst_n;
  logic i2c_scl_padoen_o, i2c_sda_padoen_o;
  logic i2c_scl_pad_i, i2c_sda_pad_i;
  logic scl_in, sda_in, scl_oe, sda_oe;
  logic recover_req, recover_busy, bus_busy;
  logic start_det, stop_det, stuck_err, err_clr;
  logic tb_scl_low, tb_sda_low;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic sb_en = 1'b0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Wired-AND bus: the DUT or an external device pulls a line low.
  assign scl_in = ~scl_oe & ~tb_scl_low;
  assign sda_in = ~sda_oe & ~tb_sda_low;

  i2c_bus_conditioner #(
    .FILTER_LEN    (4),
    .RECOVER_HALF  (10),
    .STUCK_TIMEOUT (100)
  ) dut (
    .clk_clk          (clk),
    .reset_reset_n    (rst_n),
    .i2c_scl_pad_o    (1'b0),
    .i2c_sda_pad_o    (1'b0),
    .i2c_scl_padoen_o (i2c_scl_padoen_o),
    .i2c_sda_padoen_o (i2c_sda_padoen_o),
    .i2c_scl_pad_i    (i2c_scl_pad_i),
    .i2c_sda_pad_i    (i2c_sda_pad_i),
    .scl_in           (scl_in),
    .sda_in           (sda_in),
    .scl_oe           (scl_oe),
    .sda_oe           (sda_oe),
    .recover_req      (recover_req),
    .recover_busy     (recover_busy),
    .bus_busy         (bus_busy),
    .start_det        (start_det),
    .stop_det         (stop_det),
    .stuck_err        (stuck_err),
    .err_clr          (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sb_pop(input logic [1:0] ev, input string tag);
    logic [1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_underflow"}, exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      check(tag, ev, e);
    end
  endtask

  // Detector monitor: each pulse pops an expected event and must last one cycle.
  int start_run = 0;
  int stop_run = 0;
  always @(negedge clk) begin
    if (rst_n && sb_en) begin
      if (start_det) begin
        start_run++;
        if (start_run == 1) sb_pop(EV_START, "start_det");
      end else if (start_run > 0) begin
        check("start_width", start_run, 1);
        start_run = 0;
      end
      if (stop_det) begin
        stop_run++;
        if (stop_run == 1) sb_pop(EV_STOP, "stop_det");
      end else if (stop_run > 0) begin
        check("stop_width", stop_run, 1);
        stop_run = 0;
      end
    end
  end

`ifdef I2C_COND_RECOVERY_EN
  task automatic run_recovery(input int release_at, input int stretch_at,
                              input int extra_req_at, output int pulses);
    int   rel_cnt, rise_cyc, a_cyc, b_cyc, str_cyc, hold, guard;
    logic prev_scl, pad_ok;
    rel_cnt = 0; rise_cyc = 0; a_cyc = -1; b_cyc = -1; str_cyc = -1;
    hold = 0; guard = 0; prev_scl = 1'b0; pad_ok = 1'b1; pulses = 0;
    tb_sda_low = 1'b1;
    step(10);
    @(negedge clk); recover_req = 1'b1;
    @(negedge clk); recover_req = 1'b0;
    check("rec_entry", recover_busy, 1);
    while (recover_busy && guard < 2000) begin
      recover_req = 1'b0;
      if (i2c_scl_pad_i !== 1'b1 || i2c_sda_pad_i !== 1'b1) pad_ok = 1'b0;
      if (hold > 0) begin
        hold--;
        if (hold == 0) begin
          tb_scl_low = 1'b0;
          str_cyc = cyc;
        end
      end
      if (scl_oe && !prev_scl && !sda_oe) rise_cyc = cyc;
      if (scl_oe && !prev_scl && str_cyc >= 0) begin
        check("rec_stretch_high", cyc - str_cyc, 16);
        str_cyc = -2;
      end
      if (!scl_oe && prev_scl && !sda_oe) begin
        pulses++;
        rel_cnt++;
        check("rec_low_width", cyc - rise_cyc, 10);
        if (rel_cnt == release_at) tb_sda_low = 1'b0;
        if (rel_cnt == extra_req_at) recover_req = 1'b1;
        if (rel_cnt == stretch_at) begin
          tb_scl_low = 1'b1;
          hold = 50;
        end
      end
      if (scl_oe && sda_oe && a_cyc < 0) a_cyc = cyc;
      if (!scl_oe && sda_oe && a_cyc >= 0 && b_cyc < 0) b_cyc = cyc;
      prev_scl = scl_oe;
      @(negedge clk);
      guard++;
    end
    recover_req = 1'b0;
    check("rec_done", recover_busy, 0);
    check("rec_stop_a", b_cyc - a_cyc, 10);
    check("rec_stop_bc", cyc - b_cyc, 20);
    check("rec_pad_i_high", pad_ok, 1);
    check("rec_bus_idle", bus_busy, 0);
    if (stretch_at > 0) check("rec_stretch_seen", str_cyc, -2);
  endtask
`endif

  initial begin
    int lat, c0, n;
    logic min_pad;
    rst_n = 1'b0;
    i2c_scl_padoen_o = 1'b1;
    i2c_sda_padoen_o = 1'b1;
    recover_req = 1'b0;
    err_clr = 1'b0;
    tb_scl_low = 1'b0;
    tb_sda_low = 1'b0;

    step(3);
    @(negedge clk);
    check("reset_vals", {scl_oe, sda_oe, recover_busy, bus_busy, start_det, stop_det,
                         stuck_err, i2c_scl_pad_i, i2c_sda_pad_i}, 9'b000000011);
    step(1);
    rst_n = 1'b1;
    step(10);

    // Core to pin: one clock of latency.
    i2c_scl_padoen_o = 1'b0;
    @(negedge clk); check("c2p_hold", scl_oe, 0);
    @(negedge clk); check("c2p_latency", scl_oe, 1);
    i2c_scl_padoen_o = 1'b1;
    step(15);

    // A 3-clock glitch must not pass the filter.
    min_pad = 1'b1;
    tb_scl_low = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 3) tb_scl_low = 1'b0;
      @(negedge clk);
      if (i2c_scl_pad_i == 1'b0) min_pad = 1'b0;
    end
    check("glitch3_filtered", min_pad, 1);
    step(5);

    // A 4-clock pulse passes with 2 + FILTER_LEN latency.
    lat = -1;
    tb_scl_low = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 4) tb_scl_low = 1'b0;
      @(negedge clk);
      if (i2c_scl_pad_i == 1'b0 && lat < 0) lat = k;
    end
    check("p2c_latency", lat, 6);
    step(5);

    // START, repeated START and STOP.
    sb_en = 1'b1;
    exp_q.push_back(EV_START);
    tb_sda_low = 1'b1; step(10);
    check("start_busy", bus_busy, 1);
    check("start_pad_sda", i2c_sda_pad_i, 0);
    tb_scl_low = 1'b1; step(10);
    tb_sda_low = 1'b0; step(10);
    tb_scl_low = 1'b0; step(10);
    exp_q.push_back(EV_START);
    tb_sda_low = 1'b1; step(10);
    check("rep_start_busy", bus_busy, 1);
    exp_q.push_back(EV_STOP);
    tb_sda_low = 1'b0; step(10);
    check("stop_idle", bus_busy, 0);
    check("sb_drain_startstop", exp_q.size(), 0);

    // Stuck SDA.
    check("stuck_pre", stuck_err, 0);
    exp_q.push_back(EV_START);
    tb_sda_low = 1'b1;
    c0 = cyc;
    lat = -1;
    for (int k = 0; k < 200 && lat < 0; k++) begin
      @(negedge clk);
      if (stuck_err) lat = cyc - c0;
    end
    check("stuck_latency_ok", (lat >= 104 && lat <= 110), 1);
    exp_q.push_back(EV_STOP);
    tb_sda_low = 1'b0; step(20);
    check("stuck_sticky", stuck_err, 1);
    err_clr = 1'b1; step(1); err_clr = 1'b0;
    @(negedge clk); check("stuck_cleared", stuck_err, 0);
    step(50);
    check("stuck_stays_clear", stuck_err, 0);

    // Clear while the counter is saturated: set wins.
    exp_q.push_back(EV_START);
    tb_sda_low = 1'b1;
    for (int k = 0; k < 200 && !stuck_err; k++) @(negedge clk);
    step(1);
    err_clr = 1'b1; step(1); err_clr = 1'b0;
    @(negedge clk); check("stuck_set_wins", stuck_err, 1);
    exp_q.push_back(EV_STOP);
    tb_sda_low = 1'b0; step(20);
    err_clr = 1'b1; step(1); err_clr = 1'b0;
    @(negedge clk); check("stuck_cleared2", stuck_err, 0);
    step(5);
    check("sb_drain_stuck", exp_q.size(), 0);
    sb_en = 1'b0;

`ifdef I2C_COND_RECOVERY_EN
    run_recovery(3, 0, 1, n);
    check("rec_pulses_3", n, 3);
    step(20);
    run_recovery(0, 0, 0, n);
    tb_sda_low = 1'b0;
    check("rec_pulses_9", n, 9);
    step(20);
    run_recovery(1, 1, 0, n);
    check("rec_pulses_stretch", n, 1);
    step(20);
    @(negedge clk); recover_req = 1'b1;
    @(negedge clk); recover_req = 1'b0;
    step(3);
    check("rec_pre_rst_oe", scl_oe, 1);
    #2 rst_n = 1'b0;
    #1 check("rec_rst_async", {scl_oe, sda_oe, recover_busy}, 3'b000);
    step(2);
    rst_n = 1'b1;
    step(10);
    check("rec_rst_pad_i", {i2c_scl_pad_i, i2c_sda_pad_i}, 2'b11);
`else
    @(negedge clk); recover_req = 1'b1;
    @(negedge clk); recover_req = 1'b0;
    step(3);
    check("norec_busy", recover_busy, 0);
    check("norec_oe", {scl_oe, sda_oe}, 2'b00);
    step(5);
`endif

    // Reset in the middle of core-driven traffic.
    i2c_sda_padoen_o = 1'b0; step(12);
    check("mt_busy_pre", bus_busy, 1);
    i2c_scl_padoen_o = 1'b0; step(3);
    check("mt_oe_pre", {scl_oe, sda_oe}, 2'b11);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("mt_reset", {scl_oe, sda_oe, recover_busy, bus_busy, start_det, stop_det,
                          stuck_err, i2c_scl_pad_i, i2c_sda_pad_i}, 9'b000000011);
    i2c_scl_padoen_o = 1'b1;
    i2c_sda_padoen_o = 1'b1;
    step(3);
    rst_n = 1'b1;
    step(10);
    check("mt_pad_i_idle", {i2c_scl_pad_i, i2c_sda_pad_i}, 2'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
